// File: rtl/case_4_sdiv_13s_8s_13_seq.sv
// Sequential 13s/8s signed divider (radix-2 restoring, C semantics), start/done handshake, ce freezes all state.
// Latency din0_WIDTH+2 cycles; `define CASE_4_SDIV_ZERO_BYPASS_EN to finish zero-divisor requests in 2 cycles.
module case_4_sdiv_13s_8s_13_seq #(
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 13
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int CW = $clog2(W0);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [W0-1:0]   r_a;
  logic [W1-1:0]   r_b;
  logic [W1:0]     r_r;
  logic [CW-1:0]   r_cnt;
  logic            r_sq, r_sr, r_dz;

  logic            w_accept, w_zero, w_skip, w_ge;
  logic [W0-1:0]   w_a_abs;
  logic [W1-1:0]   w_b_abs, w_rmag;
  logic [W1+1:0]   w_r_sh;
  logic [W1:0]     w_r_nxt;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_zero   = (din1 == '0);
`ifdef CASE_4_SDIV_ZERO_BYPASS_EN
  assign w_skip   = w_zero;
`else
  assign w_skip   = 1'b0;
`endif

  // Magnitudes fit unsigned in the operand width, including the most negative values.
  assign w_a_abs = din0[W0-1] ? (~din0 + 1'b1) : din0;
  assign w_b_abs = din1[W1-1] ? (~din1 + 1'b1) : din1;

  assign w_r_sh  = {r_r, r_a[W0-1]};
  assign w_ge    = (w_r_sh >= {2'b00, r_b});
  assign w_r_nxt = w_ge ? (W1+1)'(w_r_sh - {2'b00, r_b}) : w_r_sh[W1:0];
  assign w_rmag  = r_r[W1-1:0];

  always_ff @(posedge ap_clk) begin
    if (ap_rst)
      r_state <= S_IDLE;
    else if (ce)
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = w_skip ? S_SIGN : S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == CW'(W0 - 1)) w_state_nxt = S_SIGN;
      end
      S_SIGN: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? (w_skip ? S_SIGN : S_CALC) : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_sq        <= 1'b0;
      r_sr        <= 1'b0;
      r_dz        <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      if (w_accept) begin
        r_a   <= w_a_abs;
        r_b   <= w_b_abs;
        r_r   <= '0;
        r_cnt <= '0;
        r_sq  <= din0[W0-1] ^ din1[W1-1];
        r_sr  <= din0[W0-1];
        r_dz  <= w_zero;
      end else if (r_state == S_CALC) begin
        // Quotient bits shift into the vacated low end of the dividend register.
        r_r   <= w_r_nxt;
        r_a   <= {r_a[W0-2:0], w_ge};
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_SIGN) begin
        quot        <= r_dz ? '1 : (r_sq ? -r_a : r_a);
        rem         <= r_dz ? '0 : (r_sr ? -w_rmag : w_rmag);
        div_by_zero <= r_dz;
      end
    end
  end

endmodule

// File: tb/tb_case_4_sdiv_13s_8s_13_seq.sv
// Directed bench for the 13s/8s sequential divider: results, latency, handshake, ce and reset.
module tb_case_4_sdiv_13s_8s_13_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst, ce, start;
  logic [12:0] din0;
  logic [7:0]  din1;
  logic        busy, done, div_by_zero;
  logic [12:0] quot;
  logic [7:0]  rem;

  int n_chk = 0;
  int n_pass = 0;
  int lat, bcnt, seen;

`ifdef CASE_4_SDIV_ZERO_BYPASS_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 15;
`endif

  case_4_sdiv_13s_8s_13_seq dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .busy(busy), .done(done),
    .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic int m13(input int v);
    return v & 32'h1FFF;
  endfunction

  function automatic int m8(input int v);
    return v & 32'hFF;
  endfunction

  task automatic check_res(input string tag, input int q, input int r, input int dz);
    check({tag, "_quot"}, int'(quot), m13(q));
    check({tag, "_rem"}, int'(rem), m8(r));
    check({tag, "_dbz"}, int'(div_by_zero), dz);
  endtask

  task automatic idle();
    @(posedge ap_clk); #1;
  endtask

  // Issues a start from the current sample point and returns at the sample where done is seen.
  // lat_o counts edges from the accepting edge through the edge that raised done.
  task automatic op(input logic [12:0] a, input logic [7:0] b, input int poke_at,
                    input int ce_at, input int ce_len, output int lat_o, output int bcnt_o);
    int n = 0;
    int bc = 0;
    din0  = a;
    din1  = b;
    start = 1'b1;
    do begin
      @(posedge ap_clk); #1;
      n++;
      start = (n == poke_at);
      if (n == poke_at) begin
        din0 = 13'd50;
        din1 = 8'd5;
      end
      ce = !(n >= ce_at && n < ce_at + ce_len);
      if (busy) bc++;
    end while (!done && n < 200);
    ce    = 1'b1;
    start = 1'b0;
    if (!done) check("timeout", 0, 1);
    lat_o  = n;
    bcnt_o = bc;
  endtask

  initial begin
    ap_rst = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check_res("rst", 0, 0, 0);
    ap_rst = 1'b0;
    idle();

    op(13'd100, 8'd7, 0, 0, 0, lat, bcnt);
    check("p7_lat", lat, 15);
    check("p7_busy_cycles", bcnt, 14);
    check_res("p7", 14, 2, 0);
    idle();
    check("done_pulse", int'(done), 0);

    op(13'(-100), 8'd7, 0, 0, 0, lat, bcnt);
    check_res("n_p", -14, -2, 0);
    idle();
    op(13'd100, 8'(-7), 0, 0, 0, lat, bcnt);
    check_res("p_n", -14, 2, 0);
    idle();
    op(13'(-100), 8'(-7), 0, 0, 0, lat, bcnt);
    check_res("n_n", 14, -2, 0);
    idle();

    op(13'h1000, 8'hFF, 0, 0, 0, lat, bcnt);
    check_res("ovf", 'h1000, 0, 0);
    idle();
    op(13'd4095, 8'h80, 0, 0, 0, lat, bcnt);
    check_res("max_min", -31, 127, 0);
    idle();
    op(13'h1000, 8'd127, 0, 0, 0, lat, bcnt);
    check_res("min_max", -32, -32, 0);
    idle();

    op(13'd55, 8'd0, 0, 0, 0, lat, bcnt);
    check("dz_lat", lat, ZLAT);
    check_res("dz", 'h1FFF, 0, 1);
    idle();
    check("dz_hold", int'(div_by_zero), 1);
    op(13'd9, 8'd3, 0, 0, 0, lat, bcnt);
    check_res("after_dz", 3, 0, 0);
    idle();

    op(13'd100, 8'd7, 5, 0, 0, lat, bcnt);
    check("poke_lat", lat, 15);
    check_res("poke", 14, 2, 0);
    idle();

    op(13'd100, 8'd7, 0, 0, 0, lat, bcnt);
    check_res("b2b_first", 14, 2, 0);
    op(13'(-100), 8'(-7), 0, 0, 0, lat, bcnt);
    check("b2b_lat", lat, 15);
    check_res("b2b_second", 14, -2, 0);
    idle();

    op(13'd100, 8'd7, 0, 5, 4, lat, bcnt);
    check("ce_lat", lat, 19);
    check_res("ce", 14, 2, 0);
    idle();

    din0 = 13'd100; din1 = 8'd7; start = 1'b1;
    idle();
    start = 1'b0;
    repeat (6) idle();
    ap_rst = 1'b1;
    idle();
    ap_rst = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check_res("mid_rst", 0, 0, 0);
    seen = 0;
    repeat (20) begin
      idle();
      if (done) seen++;
    end
    check("mid_rst_no_done", seen, 0);
    op(13'd9, 8'd3, 0, 0, 0, lat, bcnt);
    check("post_rst_lat", lat, 15);
    check_res("post_rst", 3, 0, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
